audio_stream_ctrl: RTL

Stereo audio sample scheduler between the sc1 CPU's memory-mapped audio registers and the AXI-Stream audio output (`audio_data`/`audio_id`/`audio_valid`/`audio_ready`) on the KV260 top.
- Buffers CPU-written stereo frames in a small FIFO.
- Paces output at a fixed sample rate derived from `clk`.
- Serialises each frame as a left word then a right word under the valid/ready handshake.
- Inserts silence and counts underruns when the CPU falls behind.

---
 rtl/audio_stream_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/audio_stream_ctrl.sv
// Stereo audio frame scheduler: buffers CPU-written {left,right} frames, paces
// them at a fixed frame rate and serialises each as a left then a right stream word.
module audio_stream_ctrl #(
    parameter int AUDIO_WIDTH  = 16,
    parameter int BUFFER_DEPTH = 4,
    parameter int SAMPLE_DIV   = 2083
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [2*AUDIO_WIDTH-1:0] wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic [BUFFER_DEPTH:0]    level,
    output logic [15:0]              underrun_count,
    input  logic                     underrun_clear,
    output logic [31:0]              audio_data,
    output logic                     audio_id,
    output logic                     audio_valid,
    input  logic                     audio_ready,
    output logic [1:0]               state_dbg
);
    // Stream handshake: a word transfers in a cycle where audio_valid and audio_ready
    // are both high; while valid is high and ready low, data/id hold and valid stays up.

    localparam int DEPTH = 1 << BUFFER_DEPTH;
    localparam int CW    = $clog2(SAMPLE_DIV);

    localparam logic [CW-1:0]           CNT_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0]           CNT_ONE  = CW'(1);
    localparam logic [BUFFER_DEPTH:0]   LVL_ONE  = (BUFFER_DEPTH + 1)'(1);
    localparam logic [BUFFER_DEPTH:0]   LVL_FULL = (BUFFER_DEPTH + 1)'(DEPTH);
    localparam logic [BUFFER_DEPTH-1:0] PTR_ONE  = BUFFER_DEPTH'(1);
    localparam logic [15:0]             UR_ONE   = 16'd1;
    localparam logic [15:0]             UR_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_L = 2'd1,
        SEND_R = 2'd2
    } state_t;

    logic [2*AUDIO_WIDTH-1:0] fifo_mem [DEPTH];

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    pending_q, pending_d;
    logic [BUFFER_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUFFER_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [BUFFER_DEPTH:0]   level_q, level_d;
    logic                    full_q, full_d;
    logic [15:0]             underrun_q, underrun_d;
    logic [31:0]             data_q, data_d;
    logic                    id_q, id_d;
    logic                    valid_q, valid_d;
    logic [AUDIO_WIDTH-1:0]  right_q, right_d;

    logic                     tick, hs, push, pop, load;
    logic [2*AUDIO_WIDTH-1:0] rd_word;

    function automatic logic [31:0] fmt(input logic [AUDIO_WIDTH-1:0] s);
        logic [31:0] w;
        w = '0;
        w[27 -: AUDIO_WIDTH] = s;
        return w;
    endfunction

    always_comb begin
        tick    = enable && (cnt_q == CNT_LAST);
        cnt_d   = (enable && !tick) ? cnt_q + CNT_ONE : '0;
        hs      = valid_q && audio_ready;
        push    = wr_en && !full_q;
        rd_word = fifo_mem[rd_ptr_q];
        load    = 1'b0;
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        data_d  = data_q;
        right_d = right_q;

        case (state_q)
            IDLE:   load = enable && (tick || pending_q);
            SEND_L: if (hs) begin
                state_d = SEND_R;
                id_d    = 1'b1;
                data_d  = fmt(right_q);
            end
            SEND_R: if (hs) begin
                if (enable && pending_q) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    id_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // An empty FIFO at load time yields a silent frame and counts an underrun.
        pop        = load && (level_q != '0);
        underrun_d = underrun_q;
        if (load) begin
            state_d = SEND_L;
            valid_d = 1'b1;
            id_d    = 1'b0;
            if (pop) begin
                data_d  = fmt(rd_word[2*AUDIO_WIDTH-1:AUDIO_WIDTH]);
                right_d = rd_word[AUDIO_WIDTH-1:0];
            end else begin
                data_d  = '0;
                right_d = '0;
                if (underrun_q != UR_MAX) underrun_d = underrun_q + UR_ONE;
            end
        end
        if (underrun_clear) underrun_d = '0;

        pending_d = pending_q;
        if (tick && (state_q != IDLE) && !pending_q) pending_d = 1'b1;
        if (load) pending_d = 1'b0;
        if (!enable) pending_d = 1'b0;

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) level_d = level_q + LVL_ONE;
        else if (pop && !push) level_d = level_q - LVL_ONE;
        full_d = (level_d == LVL_FULL);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            underrun_q <= '0;
            data_q     <= '0;
            id_q       <= 1'b0;
            valid_q    <= 1'b0;
            right_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            underrun_q <= underrun_d;
            data_q     <= data_d;
            id_q       <= id_d;
            valid_q    <= valid_d;
            right_q    <= right_d;
        end
    end

    assign full           = full_q;
    assign level          = level_q;
    assign underrun_count = underrun_q;
    assign audio_data     = data_q;
    assign audio_id       = id_q;
    assign audio_valid    = valid_q;
    assign state_dbg      = state_q;

endmodule
